// File: rtl/bit_serializer_if.sv
// Word handshake between a parallel producer and bit_serializer.
// master drives pdata/pvalid, slave answers with pready.
interface bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] pdata;
   logic             pvalid;
   logic             pready;

   modport master (
      output pdata,
      output pvalid,
      input  pready
   );

   modport slave (
      input  pdata,
      input  pvalid,
      output pready
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one word in over pdata/pvalid/pready,
// one bit per clock out on sout/sout_valid/sout_last; busy while work remains.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   bit_serializer_if.slave     pin,
   output logic                sout,
   output logic                sout_valid,
   output logic                sout_last,
   output logic                busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             hold_full_q, hold_full_d;

   logic             active;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] shifted;

   assign active     = (state_q == SHIFT);
   assign pin.pready = ~hold_full_q;
   assign accept     = pin.pvalid & ~hold_full_q;
   assign last       = (cnt_q == LAST);

   assign shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, sreg_q[WIDTH-1:1]};

   assign sout       = active & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
   assign sout_valid = active;
   assign sout_last  = active & last;
   assign busy       = active | hold_full_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      hold_full_d = hold_full_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sreg_d  = pin.pdata;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!last) begin
               sreg_d = shifted;
               cnt_d  = cnt_q + 1'b1;
               if (accept) begin
                  hold_d      = pin.pdata;
                  hold_full_d = 1'b1;
               end
            end else begin
               // A held word always goes before a new one, keeping accept order;
               // a fresh word on the last bit skips the holding register.
               cnt_d = '0;
               if (hold_full_q) begin
                  sreg_d      = hold_q;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  sreg_d = pin.pdata;
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer.
// Covers MSB/LSB order, hold/bypass paths, reset abort and WIDTH=4.
module tb_bit_serializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(8)) m8 ();
   bit_serializer_if #(.WIDTH(8)) l8 ();
   bit_serializer_if #(.WIDTH(4)) m4 ();

   logic m8_sout, m8_valid, m8_last, m8_busy;
   logic l8_sout, l8_valid, l8_last, l8_busy;
   logic m4_sout, m4_valid, m4_last, m4_busy;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
      .clk(clk), .rst(rst), .pin(m8.slave),
      .sout(m8_sout), .sout_valid(m8_valid),
      .sout_last(m8_last), .busy(m8_busy)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
      .clk(clk), .rst(rst), .pin(l8.slave),
      .sout(l8_sout), .sout_valid(l8_valid),
      .sout_last(l8_last), .busy(l8_busy)
   );

   bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
      .clk(clk), .rst(rst), .pin(m4.slave),
      .sout(m4_sout), .sout_valid(m4_valid),
      .sout_last(m4_last), .busy(m4_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0]  w8;
      logic [15:0] w16;
      logic [11:0] exp12;
      logic [11:0] got12;
      logic [11:0] last12;
      logic [3:0]  win;
      logic [3:0]  words [3];
      int          n, hits, idx, first, lastpos;
      bit          acc;

      m8.pdata = '0; m8.pvalid = 1'b0;
      l8.pdata = '0; l8.pvalid = 1'b0;
      m4.pdata = '0; m4.pvalid = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // reset state
      chk("rst_pready", 32'(m8.pready), 32'd1);
      chk("rst_sout", 32'(m8_sout), 32'd0);
      chk("rst_valid", 32'(m8_valid), 32'd0);
      chk("rst_last", 32'(m8_last), 32'd0);
      chk("rst_busy", 32'(m8_busy), 32'd0);

      // 1: single word, first bit right after accept edge
      m8.pdata = 8'hB0; m8.pvalid = 1'b1;
      step();
      m8.pvalid = 1'b0;
      w8 = 8'hB0;
      for (int i = 0; i < 8; i++) begin
         chk("t1_sout", 32'(m8_sout), 32'(w8[7-i]));
         chk("t1_valid", 32'(m8_valid), 32'd1);
         chk("t1_last", 32'(m8_last), 32'(i == 7));
         step();
      end
      chk("t1_valid_end", 32'(m8_valid), 32'd0);
      chk("t1_busy_end", 32'(m8_busy), 32'd0);
      chk("t1_sout_end", 32'(m8_sout), 32'd0);
      step();

      // 2: two words back to back through the holding register
      m8.pdata = 8'hB0; m8.pvalid = 1'b1;
      step();
      w16 = 16'hB0DA;
      chk("t2_pready0", 32'(m8.pready), 32'd1);
      chk("t2_sout0", 32'(m8_sout), 32'(w16[15]));
      m8.pdata = 8'hDA;
      step();
      m8.pvalid = 1'b0;
      for (int i = 1; i < 16; i++) begin
         chk("t2_sout", 32'(m8_sout), 32'(w16[15-i]));
         chk("t2_valid", 32'(m8_valid), 32'd1);
         chk("t2_last", 32'(m8_last), 32'(i == 7 || i == 15));
         chk("t2_pready", 32'(m8.pready), 32'(i >= 8));
         step();
      end
      chk("t2_valid_end", 32'(m8_valid), 32'd0);
      chk("t2_busy_end", 32'(m8_busy), 32'd0);
      step();

      // 3: next word offered only in the last-bit cycle -> bypass
      m8.pdata = 8'hB0; m8.pvalid = 1'b1;
      step();
      m8.pvalid = 1'b0;
      w8 = 8'hB0;
      for (int i = 0; i < 8; i++) begin
         chk("t3_sout_a", 32'(m8_sout), 32'(w8[7-i]));
         if (i == 7) begin
            m8.pdata = 8'h0F; m8.pvalid = 1'b1;
         end
         step();
         m8.pvalid = 1'b0;
      end
      w8 = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         chk("t3_sout_b", 32'(m8_sout), 32'(w8[7-i]));
         chk("t3_valid_b", 32'(m8_valid), 32'd1);
         chk("t3_pready", 32'(m8.pready), 32'd1);
         step();
      end
      chk("t3_valid_end", 32'(m8_valid), 32'd0);
      step();

      // 5: reset mid-word with a held word
      m8.pdata = 8'hB0; m8.pvalid = 1'b1;
      step();
      m8.pdata = 8'hDA;
      step();
      m8.pvalid = 1'b0;
      chk("t5_held", 32'(m8.pready), 32'd0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_valid", 32'(m8_valid), 32'd0);
      chk("t5_sout", 32'(m8_sout), 32'd0);
      chk("t5_pready", 32'(m8.pready), 32'd1);
      chk("t5_busy", 32'(m8_busy), 32'd0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (m8_valid) n++;
      end
      chk("t5_no_held_bits", 32'(n), 32'd0);

      // 4: LSB-first, 8'h0D gives 1,0,1,1,0,0,0,0 and one 1011 match
      l8.pdata = 8'h0D; l8.pvalid = 1'b1;
      step();
      l8.pvalid = 1'b0;
      w8 = 8'b1011_0000;
      win = '0;
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         chk("t4_sout", 32'(l8_sout), 32'(w8[7-i]));
         chk("t4_valid", 32'(l8_valid), 32'd1);
         win = {win[2:0], l8_sout};
         if (i >= 3 && win == 4'b1011) hits++;
         step();
      end
      chk("t4_hits", 32'(hits), 32'd1);
      chk("t4_idle", 32'(l8_valid), 32'd0);

      // 6: WIDTH=4 stream A,5,F with pvalid held
      words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
      exp12 = 12'hA5F;
      got12 = '0; last12 = '0;
      idx = 0; n = 0; first = -1; lastpos = -1;
      m4.pdata = words[0]; m4.pvalid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         acc = m4.pvalid && m4.pready;
         if (m4_valid) begin
            if (first < 0) first = c;
            lastpos = c;
            if (n < 12) begin
               got12 = {got12[10:0], m4_sout};
               last12 = {last12[10:0], m4_last};
            end
            n++;
         end
         step();
         if (acc) begin
            idx++;
            if (idx >= 3) m4.pvalid = 1'b0;
            else m4.pdata = words[idx];
         end
      end
      chk("t6_nbits", 32'(n), 32'd12);
      chk("t6_contig", 32'(lastpos - first + 1), 32'd12);
      chk("t6_bits", 32'(got12), 32'(exp12));
      chk("t6_last", 32'(last12), 32'h111);
      chk("t6_busy_end", 32'(m4_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
